// File: rtl/rr_datapath_arbiter_if.sv
// Requester, datapath and response signals of rr_datapath_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding logic.
interface rr_datapath_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 64
);
    logic           ena;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           dp_in_valid;
    logic [W-1:0]   dp_in_data;
    logic           dp_out_valid;
    logic [W-1:0]   dp_out_data;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           err_orphan;

    modport slave (
        input  ena, req, req_data, dp_out_valid, dp_out_data,
        output gnt, dp_in_valid, dp_in_data, rsp_valid, rsp_data, err_orphan
    );

    modport master (
        output ena, req, req_data, dp_out_valid, dp_out_data,
        input  gnt, dp_in_valid, dp_in_data, rsp_valid, rsp_data, err_orphan
    );
endinterface

// File: rtl/rr_datapath_arbiter.sv
// Round-robin arbiter with burst lock that shares one fixed-latency datapath between N requesters.
// Each launch is tagged with its owner ID, and the result is routed back to that owner.
module rr_datapath_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 64,
    parameter int unsigned DP_LAT = 3,
    parameter int unsigned BURST  = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    rr_datapath_arbiter_if.slave bus
);
    localparam int unsigned     IDW       = $clog2(N);
    localparam int unsigned     BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]   BURST_MAX = BW'(BURST - 1);
    localparam logic [IDW-1:0]  ID_LAST   = IDW'(N - 1);

    logic [IDW-1:0] r_rr_ptr;
    logic [BW-1:0]  r_burst_cnt;
    logic [IDW-1:0] r_last_id;
    logic           r_last_vld;
    logic           r_dp_in_valid;
    logic [W-1:0]   r_dp_in_data;
    logic [IDW-1:0] r_launch_id;
    logic           r_tag_vld [DP_LAT];
    logic [IDW-1:0] r_tag_id  [DP_LAT];
    logic [N-1:0]   r_rsp_valid;
    logic [W-1:0]   r_rsp_data;
    logic           r_err_orphan;

    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_id;
    logic [IDW-1:0] w_idx;
    logic [N-1:0]   w_gnt;
    logic [W-1:0]   w_gnt_data;
    logic           w_same_owner;
    logic [BW-1:0]  w_burst_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_head_vld;
    logic [IDW-1:0] w_head_id;

    // The scan starts at r_rr_ptr. The first requester found at the smallest offset wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        if (nrst && bus.ena) begin
            for (int unsigned k = 0; k < N; k++) begin
                w_idx = IDW'((32'(r_rr_ptr) + k) % N);
                if (!w_gnt_any && bus.req[w_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_gnt      = w_gnt_any ? (N'(1) << w_gnt_id) : '0;
        w_gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IDW'(i) == w_gnt_id) w_gnt_data = bus.req_data[i*W +: W];
        end
    end

    // The pointer stays on the owner until its burst count reaches BURST-1. Then the pointer rotates.
    always_comb begin
        w_same_owner = r_last_vld && (w_gnt_id == r_last_id);
        w_burst_nxt  = (w_same_owner && (r_burst_cnt != BURST_MAX)) ? r_burst_cnt + 1'b1 : '0;
        if (w_burst_nxt != BURST_MAX) w_ptr_nxt = w_gnt_id;
        else                          w_ptr_nxt = (w_gnt_id == ID_LAST) ? '0 : w_gnt_id + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            r_last_id     <= '0;
            r_last_vld    <= 1'b0;
            r_dp_in_valid <= 1'b0;
            r_dp_in_data  <= '0;
            r_launch_id   <= '0;
        end else begin
            r_dp_in_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_rr_ptr     <= w_ptr_nxt;
                r_burst_cnt  <= w_burst_nxt;
                r_last_id    <= w_gnt_id;
                r_last_vld   <= 1'b1;
                r_dp_in_data <= w_gnt_data;
                r_launch_id  <= w_gnt_id;
            end
        end
    end

    assign w_head_vld = r_tag_vld[DP_LAT-1];
    assign w_head_id  = r_tag_id[DP_LAT-1];

    // The tag pipe is fed from the launch register. Its head lines up with dp_out_valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_id[i]  <= '0;
            end
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_tag_vld[0] <= r_dp_in_valid;
            r_tag_id[0]  <= r_launch_id;
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            r_rsp_valid <= '0;
            if (bus.dp_out_valid) begin
                if (w_head_vld) begin
                    r_rsp_valid <= N'(1) << w_head_id;
                    r_rsp_data  <= bus.dp_out_data;
                end else begin
                    r_err_orphan <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.dp_in_valid = r_dp_in_valid;
    assign bus.dp_in_data  = r_dp_in_data;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.err_orphan  = r_err_orphan;
endmodule

// File: tb/tb_rr_datapath_arbiter.sv
// Testbench for rr_datapath_arbiter. It models a pass-through datapath and keeps a queue of expected responses.
// A second instance with BURST=3 exercises the burst lock.
module tb_rr_datapath_arbiter;
    localparam int unsigned N      = 4;
    localparam int unsigned W      = 64;
    localparam int unsigned DP_LAT = 3;

    typedef struct {
        int unsigned id;
        logic [W-1:0] data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    rr_datapath_arbiter_if #(.N(N), .W(W)) bus   ();
    rr_datapath_arbiter_if #(.N(N), .W(W)) bus_b ();

    rr_datapath_arbiter #(.N(N), .W(W), .DP_LAT(DP_LAT), .BURST(1)) u_dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    rr_datapath_arbiter #(.N(N), .W(W), .DP_LAT(DP_LAT), .BURST(3)) u_dut_b (
        .clk (clk),
        .nrst(nrst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_v = 1'b0;
    logic [W-1:0] prev_d = '0;
    int unsigned seq_b [14] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
        step();
    endtask

    // Pass-through datapath model with a fixed latency. It has no reset, so late results still come out.
    logic [DP_LAT-1:0] dp_v = '0;
    logic [W-1:0]      dp_d [DP_LAT];
    logic              inj_vld = 1'b0;
    logic [W-1:0]      inj_data = '0;

    always @(posedge clk) begin
        dp_v    <= {dp_v[DP_LAT-2:0], bus.dp_in_valid};
        dp_d[0] <= bus.dp_in_data;
        for (int i = DP_LAT - 1; i > 0; i--) dp_d[i] <= dp_d[i-1];
    end

    assign bus.dp_out_valid   = dp_v[DP_LAT-1] | inj_vld;
    assign bus.dp_out_data    = inj_vld ? inj_data : dp_d[DP_LAT-1];
    assign bus_b.dp_out_valid = 1'b0;
    assign bus_b.dp_out_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks launch and response traffic, and records each grant as an expected response.
    always @(negedge clk) begin
        if (!nrst) begin
            q.delete();
            prev_v = 1'b0;
        end else begin
            check("dp_in_valid", 64'(bus.dp_in_valid), 64'(prev_v));
            if (prev_v) check("dp_in_data", bus.dp_in_data, prev_d);
            if (q.size() != 0 && q[0].due < cyc) begin
                check("rsp_missing", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            if (bus.rsp_valid != '0) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << mon_e.id);
                    check("rsp_data", bus.rsp_data, mon_e.data);
                    check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
            check("gnt_onehot", 64'($onehot0(bus.gnt)), 64'd1);
            prev_v = |bus.gnt;
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) begin
                    prev_d = bus.req_data[i*W +: W];
                    q.push_back('{id: i, data: bus.req_data[i*W +: W], due: cyc + DP_LAT + 2});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst           = 1'b0;
        bus.ena        = 1'b1;
        bus.req        = '1;
        bus.req_data   = '0;
        bus_b.ena      = 1'b1;
        bus_b.req      = '0;
        bus_b.req_data = '0;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 64'hD000_0000_0000_0000 | 64'(i);

        // Reset values, with requests pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
        check("rst_dp_in_data", bus.dp_in_data, 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_err", 64'(bus.err_orphan), 64'd0);
        step();
        nrst    = 1'b1;
        bus.req = '0;
        step();

        // Burst lock with BURST=3. Requester 0 drops its request after its second grant.
        bus_b.req = 4'b0011;
        foreach (seq_b[k]) begin
            @(negedge clk);
            check("t3_gnt", 64'(bus_b.gnt), 64'(1) << seq_b[k]);
            step();
        end
        bus_b.req = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            check("t3_drop_gnt", 64'(bus_b.gnt), 64'h2);
            step();
        end
        bus_b.req = '0;

        // Pure round robin, with all requesters active.
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_gnt", 64'(bus.gnt), 64'(1) << (k % 4));
            step();
        end
        bus.req = '0;
        drain();

        // A single requester, with explicit launch timing.
        bus.req_data[2*W +: W] = 64'hA5;
        bus.req = 4'b0100;
        @(negedge clk);
        check("t2_gnt", 64'(bus.gnt), 64'h4);
        step();
        bus.req = '0;
        @(negedge clk);
        check("t2_dp_in_valid", 64'(bus.dp_in_valid), 64'd1);
        check("t2_dp_in_data", bus.dp_in_data, 64'hA5);
        step();
        drain();

        // ena low while two launches are in flight. Afterwards arbitration resumes at the saved pointer.
        bus.req = 4'b1111;
        @(negedge clk);
        check("t4_gnt_a", 64'(bus.gnt), 64'h8);
        step();
        @(negedge clk);
        check("t4_gnt_b", 64'(bus.gnt), 64'h1);
        step();
        bus.ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t4_gnt_off", 64'(bus.gnt), 64'd0);
            step();
        end
        check("t4_inflight_done", 64'(q.size()), 64'd0);
        bus.ena = 1'b1;
        @(negedge clk);
        check("t4_resume_a", 64'(bus.gnt), 64'h2);
        step();
        @(negedge clk);
        check("t4_resume_b", 64'(bus.gnt), 64'h4);
        step();
        bus.req = '0;
        drain();

        // An orphan result while the tag pipe is empty.
        inj_vld  = 1'b1;
        inj_data = 64'hDEAD;
        @(negedge clk);
        check("t5_err_before", 64'(bus.err_orphan), 64'd0);
        step();
        inj_vld = 1'b0;
        @(negedge clk);
        check("t5_err_set", 64'(bus.err_orphan), 64'd1);
        check("t5_rsp_quiet", 64'(bus.rsp_valid), 64'd0);
        repeat (4) begin
            step();
            @(negedge clk);
            check("t5_err_sticky", 64'(bus.err_orphan), 64'd1);
        end
        step();

        // Reset while launches are in flight. The results that arrive late become orphans.
        bus.req = 4'b1111;
        repeat (3) step();
        nrst = 1'b0;
        #1;
        check("t6_gnt", 64'(bus.gnt), 64'd0);
        check("t6_dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
        check("t6_dp_in_data", bus.dp_in_data, 64'd0);
        check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t6_rsp_data", bus.rsp_data, 64'd0);
        check("t6_err_clr", 64'(bus.err_orphan), 64'd0);
        step();
        nrst    = 1'b1;
        bus.req = '0;
        for (int k = 0; k < 10 && !bus.err_orphan; k++) step();
        check("t6_late_orphan", 64'(bus.err_orphan), 64'd1);
        repeat (3) step();
        bus.req = 4'b1010;
        @(negedge clk);
        check("t6_first_gnt", 64'(bus.gnt), 64'h2);
        step();
        bus.req = '0;
        drain();
        check("t6_err_kept", 64'(bus.err_orphan), 64'd1);
        check("t3_err_b", 64'(bus_b.err_orphan), 64'd0);
        nrst = 1'b0;
        #1;
        check("final_err_clr", 64'(bus.err_orphan), 64'd0);
        step();
        nrst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
